// File: rtl/pwm_multichannel_if.sv
// -----------------------------------------------------------------------------
// pwm_multichannel_if
// Register-write port of the multi-channel PWM generator.
//   period_wr : one-cycle strobe, capture 'period' into the pending period
//   period    : period value P (PWM period is P+1 cycles)
//   duty_wr   : one-cycle strobe, capture 'duty' into pending duty of ch_sel
//   ch_sel    : target channel for duty_wr (out-of-range values are ignored)
//   duty      : duty value D (high cycles per period)
// Modports: master (control/register logic side), slave (PWM generator side).
// -----------------------------------------------------------------------------
interface pwm_multichannel_if #(
    parameter int WORD_LENGTH = 8,
    parameter int CHANNELS    = 4
);
    localparam int SEL_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

    logic                   period_wr;
    logic [WORD_LENGTH-1:0] period;
    logic                   duty_wr;
    logic [SEL_W-1:0]       ch_sel;
    logic [WORD_LENGTH-1:0] duty;

    modport master (
        output period_wr,
        output period,
        output duty_wr,
        output ch_sel,
        output duty
    );

    modport slave (
        input period_wr,
        input period,
        input duty_wr,
        input ch_sel,
        input duty
    );
endinterface

// File: rtl/pwm_multichannel.sv
// -----------------------------------------------------------------------------
// pwm_multichannel
// Multi-channel PWM generator driven by one shared free-running period counter.
// Period and duty values are written into pending registers and copied into
// active (shadow) registers only at period boundaries, so a running period is
// never altered by a write.
// Ports:
//   clk        : system clock, rising edge
//   reset      : asynchronous active-low reset
//   enable     : run PWM; low holds the counter at 0 and forces outputs low
//   regs       : register-write port (pwm_multichannel_if.slave)
//   pwm_out    : registered PWM outputs, bit i = channel i
//   period_end : registered one-cycle pulse on the final count of each period
// -----------------------------------------------------------------------------
module pwm_multichannel #(
    parameter int WORD_LENGTH = 8,
    parameter int CHANNELS    = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  enable,
    pwm_multichannel_if.slave     regs,
    output logic [CHANNELS-1:0]   pwm_out,
    output logic                  period_end
);

    localparam int SEL_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
    localparam logic [WORD_LENGTH-1:0] WORD_ZERO = {WORD_LENGTH{1'b0}};
    localparam logic [WORD_LENGTH-1:0] WORD_ONE  = WORD_LENGTH'(1);

    // Counter and period registers
    logic [WORD_LENGTH-1:0] cnt_r;
    logic [WORD_LENGTH-1:0] cnt_nxt_s;
    logic [WORD_LENGTH-1:0] per_pend_r;
    logic [WORD_LENGTH-1:0] per_pend_nxt_s;
    logic [WORD_LENGTH-1:0] per_act_r;
    logic [WORD_LENGTH-1:0] per_act_nxt_s;

    // Per-channel duty registers
    logic [WORD_LENGTH-1:0] duty_pend_r     [CHANNELS];
    logic [WORD_LENGTH-1:0] duty_pend_nxt_s [CHANNELS];
    logic [WORD_LENGTH-1:0] duty_act_r      [CHANNELS];
    logic [WORD_LENGTH-1:0] duty_act_nxt_s  [CHANNELS];

    // Control and output next-state signals
    logic                   boundary_s;
    logic                   load_s;
    logic [CHANNELS-1:0]    pwm_nxt_s;
    logic                   period_end_nxt_s;
    logic [CHANNELS-1:0]    pwm_out_r;
    logic                   period_end_r;

    assign pwm_out    = pwm_out_r;
    assign period_end = period_end_r;

    // Pending registers including same-cycle writes (bypass value used on load)
    always_comb begin
        per_pend_nxt_s = per_pend_r;
        if (regs.period_wr) begin
            per_pend_nxt_s = regs.period;
        end else begin
            per_pend_nxt_s = per_pend_r;
        end
        for (int i = 0; i < CHANNELS; i++) begin
            duty_pend_nxt_s[i] = duty_pend_r[i];
            // ch_sel values at or above CHANNELS never match, so they are dropped
            if (regs.duty_wr && (regs.ch_sel == SEL_W'(i))) begin
                duty_pend_nxt_s[i] = regs.duty;
            end else begin
                duty_pend_nxt_s[i] = duty_pend_r[i];
            end
        end
    end

    // Period counter and pending-to-active transfer
    always_comb begin
        boundary_s    = enable && (cnt_r == per_act_r);
        // While disabled the active set tracks pending so a restart uses fresh values
        load_s        = boundary_s || !enable;
        cnt_nxt_s     = cnt_r;
        per_act_nxt_s = per_act_r;
        if (!enable) begin
            cnt_nxt_s = WORD_ZERO;
        end else if (boundary_s) begin
            cnt_nxt_s = WORD_ZERO;
        end else begin
            cnt_nxt_s = cnt_r + WORD_ONE;
        end
        if (load_s) begin
            per_act_nxt_s = per_pend_nxt_s;
        end else begin
            per_act_nxt_s = per_act_r;
        end
        for (int i = 0; i < CHANNELS; i++) begin
            duty_act_nxt_s[i] = duty_act_r[i];
            if (load_s) begin
                duty_act_nxt_s[i] = duty_pend_nxt_s[i];
            end else begin
                duty_act_nxt_s[i] = duty_act_r[i];
            end
        end
    end

    // Output compare against the current count; result is registered one cycle later
    always_comb begin
        pwm_nxt_s        = {CHANNELS{1'b0}};
        period_end_nxt_s = 1'b0;
        if (enable) begin
            for (int i = 0; i < CHANNELS; i++) begin
                pwm_nxt_s[i] = (cnt_r < duty_act_r[i]);
            end
            period_end_nxt_s = boundary_s;
        end else begin
            pwm_nxt_s        = {CHANNELS{1'b0}};
            period_end_nxt_s = 1'b0;
        end
    end

    // State and output registers with asynchronous clear
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_r        <= WORD_ZERO;
            per_pend_r   <= WORD_ZERO;
            per_act_r    <= WORD_ZERO;
            pwm_out_r    <= {CHANNELS{1'b0}};
            period_end_r <= 1'b0;
            for (int i = 0; i < CHANNELS; i++) begin
                duty_pend_r[i] <= WORD_ZERO;
                duty_act_r[i]  <= WORD_ZERO;
            end
        end else begin
            cnt_r        <= cnt_nxt_s;
            per_pend_r   <= per_pend_nxt_s;
            per_act_r    <= per_act_nxt_s;
            pwm_out_r    <= pwm_nxt_s;
            period_end_r <= period_end_nxt_s;
            for (int i = 0; i < CHANNELS; i++) begin
                duty_pend_r[i] <= duty_pend_nxt_s[i];
                duty_act_r[i]  <= duty_act_nxt_s[i];
            end
        end
    end

endmodule

// File: tb/tb_pwm_multichannel.sv
// -----------------------------------------------------------------------------
// tb_pwm_multichannel
// Drives a 4-channel and a 3-channel instance with identical register writes.
// A period-level reference model predicts every output each cycle; directed
// sequences add hand-computed literal counts of high cycles per period.
// -----------------------------------------------------------------------------
module tb_pwm_multichannel;

    localparam int W = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset = 1'b1;
    logic enable;

    pwm_multichannel_if #(.WORD_LENGTH(W), .CHANNELS(4)) if4 ();
    pwm_multichannel_if #(.WORD_LENGTH(W), .CHANNELS(3)) if3 ();

    // Same write traffic to both instances
    assign if3.period_wr = if4.period_wr;
    assign if3.period    = if4.period;
    assign if3.duty_wr   = if4.duty_wr;
    assign if3.ch_sel    = if4.ch_sel;
    assign if3.duty      = if4.duty;

    logic [3:0] pwm4;
    logic       pe4;
    logic [2:0] pwm3;
    logic       pe3;

    pwm_multichannel #(.WORD_LENGTH(W), .CHANNELS(4)) dut4 (
        .clk        (clk),
        .reset      (reset),
        .enable     (enable),
        .regs       (if4),
        .pwm_out    (pwm4),
        .period_end (pe4)
    );

    pwm_multichannel #(.WORD_LENGTH(W), .CHANNELS(3)) dut3 (
        .clk        (clk),
        .reset      (reset),
        .enable     (enable),
        .regs       (if3),
        .pwm_out    (pwm3),
        .period_end (pe3)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: position within the running period plus pending/active sets
    int         m_pos;
    int         m_per_act;
    int         m_per_pend;
    int         m_duty_act  [4];
    int         m_duty_pend [4];
    logic [3:0] exp_pwm;
    logic       exp_pe;

    task automatic model_reset();
        m_pos      = 0;
        m_per_act  = 0;
        m_per_pend = 0;
        for (int i = 0; i < 4; i++) begin
            m_duty_act[i]  = 0;
            m_duty_pend[i] = 0;
        end
        exp_pwm = 4'b0000;
        exp_pe  = 1'b0;
    endtask

    task automatic load_active();
        m_per_act = m_per_pend;
        for (int i = 0; i < 4; i++) m_duty_act[i] = m_duty_pend[i];
    endtask

    // Called at each rising edge with the inputs that edge samples
    task automatic model_update();
        if (!reset) begin
            model_reset();
        end else begin
            if (if4.period_wr) m_per_pend = int'(if4.period);
            if (if4.duty_wr && int'(if4.ch_sel) < 4) m_duty_pend[if4.ch_sel] = int'(if4.duty);
            if (!enable) begin
                exp_pwm = 4'b0000;
                exp_pe  = 1'b0;
                m_pos   = 0;
                load_active();
            end else begin
                for (int i = 0; i < 4; i++) exp_pwm[i] = (m_pos < m_duty_act[i]);
                exp_pe = (m_pos == m_per_act);
                if (exp_pe) begin
                    m_pos = 0;
                    load_active();
                end else begin
                    m_pos = m_pos + 1;
                end
            end
        end
    endtask

    // Per-cycle comparison of both instances against the model
    initial begin
        forever begin
            @(negedge clk);
            checks++;
            if (pwm4 !== exp_pwm) begin
                errors++;
                $display("FAIL pwm4 got %b want %b at %0t", pwm4, exp_pwm, $time);
            end
            checks++;
            if (pe4 !== exp_pe) begin
                errors++;
                $display("FAIL pe4 got %b want %b at %0t", pe4, exp_pe, $time);
            end
            checks++;
            if (pwm3 !== exp_pwm[2:0]) begin
                errors++;
                $display("FAIL pwm3 got %b want %b at %0t", pwm3, exp_pwm[2:0], $time);
            end
            checks++;
            if (pe3 !== exp_pe) begin
                errors++;
                $display("FAIL pe3 got %b want %b at %0t", pe3, exp_pe, $time);
            end
        end
    end

    task automatic check(input string name, input int act, input int exp_v);
        checks++;
        if (act != exp_v) begin
            errors++;
            $display("FAIL %s got %0d want %0d at %0t", name, act, exp_v, $time);
        end
    endtask

    // One clock: model sees the edge, then return at the falling edge
    task automatic step();
        @(posedge clk);
        model_update();
        @(negedge clk);
    endtask

    task automatic write_period(input int p);
        if4.period_wr = 1'b1;
        if4.period    = W'(p);
        step();
        if4.period_wr = 1'b0;
    endtask

    task automatic write_duty(input int ch, input int d);
        if4.duty_wr = 1'b1;
        if4.ch_sel  = 2'(ch);
        if4.duty    = W'(d);
        step();
        if4.duty_wr = 1'b0;
    endtask

    // Step n cycles counting high cycles per channel, period_end pulses and dut3 ch0
    task automatic run_count(input int n, output int c0, output int c1, output int c2,
                             output int c3, output int cpe, output int c3ch0);
        c0 = 0; c1 = 0; c2 = 0; c3 = 0; cpe = 0; c3ch0 = 0;
        for (int i = 0; i < n; i++) begin
            step();
            c0    += int'(pwm4[0]);
            c1    += int'(pwm4[1]);
            c2    += int'(pwm4[2]);
            c3    += int'(pwm4[3]);
            cpe   += int'(pe4);
            c3ch0 += int'(pwm3[0]);
        end
    endtask

    int c0, c1, c2, c3, cpe, cx;

    initial begin
        model_reset();
        enable        = 1'b0;
        if4.period_wr = 1'b0;
        if4.period    = '0;
        if4.duty_wr   = 1'b0;
        if4.ch_sel    = '0;
        if4.duty      = '0;
        #1 reset = 1'b0;
        repeat (2) step();
        reset = 1'b1;

        // Asynchronous reset in the middle of a running period
        write_period(9);
        write_duty(0, 3);
        write_duty(1, 5);
        write_duty(2, 0);
        write_duty(3, 10);
        enable = 1'b1;
        repeat (6) step();
        check("pre_reset_ch3", int'(pwm4[3]), 1);
        @(posedge clk);
        model_update();
        #2 reset = 1'b0;
        model_reset();
        #1;
        check("async_reset_pwm", int'(pwm4), 0);
        check("async_reset_pe", int'(pe4), 0);
        @(negedge clk);
        repeat (2) step();
        reset  = 1'b1;
        enable = 1'b0;
        repeat (3) step();
        check("post_release_pwm", int'(pwm4), 0);

        // Basic PWM: P=9, duties 3/5/0/10
        write_period(9);
        write_duty(0, 3);
        write_duty(1, 5);
        write_duty(2, 0);
        write_duty(3, 10);
        enable = 1'b1;
        run_count(10, c0, c1, c2, c3, cpe, cx);
        check("basic_ch0", c0, 3);
        check("basic_ch1", c1, 5);
        check("basic_ch2", c2, 0);
        check("basic_ch3", c3, 10);
        check("basic_pe", cpe, 1);

        // Mid-period duty write at cnt=4 keeps the current period
        c0 = 0;
        for (int i = 0; i < 10; i++) begin
            if (i == 4) begin
                if4.duty_wr = 1'b1;
                if4.ch_sel  = 2'd0;
                if4.duty    = 8'd7;
            end
            step();
            if4.duty_wr = 1'b0;
            c0 += int'(pwm4[0]);
        end
        check("mid_cur_ch0", c0, 3);

        // New duty applies; boundary-cycle writes of P=4 and ch1=2 take effect next
        c0 = 0;
        for (int i = 0; i < 10; i++) begin
            if (i == 9) begin
                if4.duty_wr   = 1'b1;
                if4.ch_sel    = 2'd1;
                if4.duty      = 8'd2;
                if4.period_wr = 1'b1;
                if4.period    = 8'd4;
            end
            step();
            if4.duty_wr   = 1'b0;
            if4.period_wr = 1'b0;
            c0 += int'(pwm4[0]);
        end
        check("mid_next_ch0", c0, 7);
        run_count(5, c0, c1, c2, c3, cpe, cx);
        check("bnd_ch1", c1, 2);
        check("bnd_ch0_full", c0, 5);
        check("bnd_pe", cpe, 1);
        check("bnd_pe_last", int'(pe4), 1);

        // P=0, D=1: every cycle is a boundary
        enable = 1'b0;
        write_period(0);
        write_duty(0, 1);
        enable = 1'b1;
        for (int i = 0; i < 6; i++) begin
            step();
            check("p0_pe", int'(pe4), 1);
            check("p0_ch0", int'(pwm4[0]), 1);
        end

        // P=255, D=255: 255 high, 1 low
        enable = 1'b0;
        write_period(255);
        write_duty(0, 255);
        enable = 1'b1;
        run_count(256, c0, c1, c2, c3, cpe, cx);
        check("p255_ch0", c0, 255);
        check("p255_pe", cpe, 1);
        check("p255_last_low", int'(pwm4[0]), 0);

        // ch_sel=3 is out of range for the 3-channel instance
        enable = 1'b0;
        write_period(9);
        write_duty(3, 0);
        enable = 1'b1;
        run_count(10, c0, c1, c2, c3, cpe, cx);
        check("oor_dut3_ch0", cx, 10);
        check("oor_dut4_ch3", c3, 0);

        // Drop enable mid-period, then restart with a fresh full period
        repeat (5) step();
        enable = 1'b0;
        step();
        check("dis_pwm", int'(pwm4), 0);
        check("dis_pe", int'(pe4), 0);
        write_duty(2, 4);
        enable = 1'b1;
        run_count(10, c0, c1, c2, c3, cpe, cx);
        check("reen_ch0", c0, 10);
        check("reen_ch1", c1, 2);
        check("reen_ch2", c2, 4);
        check("reen_pe", cpe, 1);
        check("reen_pe_last", int'(pe4), 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pwm_multichannel.md
# pwm_multichannel

Parametrised multi-channel PWM generator. It drives CHANNELS independent duty-cycle outputs from one shared free-running period counter. Period and duty values are written through a simple register-write port into pending registers, and are applied glitch-free at period boundaries via shadow registers. It sits between the control/register logic and the output pins, and replaces the fixed one-hot duty decoder with arbitrary duty and period values.

## Interface
- WORD_LENGTH, 8, width of period counter, period and duty values
- CHANNELS, 4, number of PWM outputs (≥1)
- clk  input  1  system clock, rising edge
- reset  input  1  asynchronous, active-low reset
- enable  input  1  run PWM; low holds counter at 0 and forces outputs low
- period_wr  input  1  one-cycle strobe: capture period into pending period register
- period  input  WORD_LENGTH  period value P; PWM period is P+1 cycles
- duty_wr  input  1  one-cycle strobe: capture duty into pending duty of channel ch_sel
- ch_sel  input  max(1,$clog2(CHANNELS))  target channel for duty_wr
- duty  input  WORD_LENGTH  duty value D: high cycles per period
- pwm_out  output  CHANNELS  registered PWM outputs, bit i = channel i
- period_end  output  1  registered one-cycle pulse, final count of each period

## Operation
- State: cnt, per_pend, per_act, duty_pend[i], duty_act[i]. All are WORD_LENGTH wide and unsigned.
- Reset (asynchronous, reset=0): all state is 0; pwm_out=0; period_end=0.
- Writes:
  - period_wr=1: per_pend ← period.
  - duty_wr=1: duty_pend[ch_sel] ← duty.
  - If ch_sel ≥ CHANNELS, the write is ignored.
  - Writes are accepted every cycle, regardless of enable.
- Boundary: occurs when enable=1 and cnt==per_act.
  - Next cycle: cnt ← 0, per_act ← per_pend', duty_act[i] ← duty_pend'[i].
  - ' denotes the pending value including any write in the same cycle (write bypass). A write in the boundary cycle therefore takes effect in the very next period.
- Otherwise, with enable=1: cnt ← cnt+1. No wrap beyond per_act; if per_act=2^W−1, the counter wraps naturally at the boundary.
- enable=0:
  - cnt ← 0; pwm_out ← 0; period_end ← 0.
  - per_act/duty_act continuously load per_pend'/duty_pend', so the first period after enable uses the latest values.
- Output compare: pwm_out[i] ← enable & (cnt < duty_act[i]).
  - D=0: constantly low.
  - D > P: constantly high (100%).
  - Otherwise high for exactly D of every P+1 cycles, starting at period start.
- period_end ← enable & (cnt==per_act).
- P=0: cnt stays 0, period_end is high every cycle, and every cycle is a boundary.
- Writes between boundaries never alter the running period: no partial or glitched periods.

## Timing
- Every output is a flop output; none is combinational from inputs.
- Latency: pwm_out and period_end lag the cnt value they decode by 1 cycle.
- enable rise at edge k:
  - cnt=0 during cycle k.
  - First pwm_out high (if D≥1) is visible after edge k+1.
  - First period_end is visible after edge k+1+P.
- enable fall: pwm_out and period_end are 0 after the next edge.
- Pending-to-active transfer occurs on the edge following the boundary cycle, coincident with cnt returning to 0.
- reset assertion mid-period clears outputs immediately (asynchronously), without waiting for clk. After release, the block idles until enable=1 with cleared registers.

## Test plan
- Reset: drive random state, assert reset=0 between edges -> pwm_out=4'b0000 and period_end=0 immediately; all stay 0 after release with enable=0.
- Basic PWM (W=8, CH=4): P=9; duties ch0=3, ch1=5, ch2=0, ch3=10; enable=1 -> per 10-cycle period, ch0 high 3, ch1 high 5, ch2 always 0, ch3 always 1; period_end pulses once every 10 cycles.
- Mid-period update: while running P=9, write ch0 D=7 at cnt=4 -> current period keeps 3 high cycles; next period after period_end has 7 high cycles.
- Boundary-cycle write: write ch1 D=2 and P=4 in the cycle where cnt==9 -> the very next period is 5 cycles long with ch1 high for 2.
- Edge values: P=0, D=1 -> period_end constantly 1 and pwm_out[0] constantly 1. P=255, D=255 -> 255 high, 1 low per 256 cycles. Write with ch_sel out of range for CHANNELS=3 -> no channel changes.
- Enable toggle: drop enable mid-period -> outputs 0 next edge, cnt=0. Re-enable -> a full fresh period using the last written values.
